lc3_memaccess_ctrl: RTL and testbench

Sequencing controller for the LC3 MemAccess stage. It accepts one load/store request at a time from the execute/writeback side and drives the single-port data memory (dmem_addr, dmem_din, dmem_rd) cycle by cycle. Direct loads and stores (LD/LDR/ST/STR) take one memory access; indirect ones (LDI/STI) take two, with a pointer read first. It returns load data on memout, which is what the memaccess_out agent monitors.

---
 rtl/lc3_memaccess_ctrl.sv | 147 ++++++++++++++
 tb/tb_lc3_memaccess_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_memaccess_ctrl.sv
// LC3 MemAccess sequencer: drives a single-port data memory for LD/ST/LDI/STI.
// Optional sticky request-stability checker on err, enabled by LC3_MEMACC_ERR_CHECK_EN.
module lc3_memaccess_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_mode,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        dmem_en,
  output logic        dmem_rd,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_din,
  input  logic [15:0] dmem_dout,
  output logic [15:0] memout,
  output logic        rsp_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, PTR_RD, PTR_CAP, DATA, RD_CAP} state_t;

  state_t      state, state_n;
  logic        store_q, store_n;
  logic [15:0] data_q, data_n;
  logic        ready_n, en_n, rd_n, rsp_n;
  logic [15:0] addr_n, din_n, memout_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      data_q    <= 16'h0000;
      req_ready <= 1'b1;
      dmem_en   <= 1'b0;
      dmem_rd   <= 1'b0;
      dmem_addr <= 16'h0000;
      dmem_din  <= 16'h0000;
      memout    <= 16'h0000;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      store_q   <= store_n;
      data_q    <= data_n;
      req_ready <= ready_n;
      dmem_en   <= en_n;
      dmem_rd   <= rd_n;
      dmem_addr <= addr_n;
      dmem_din  <= din_n;
      memout    <= memout_n;
      rsp_valid <= rsp_n;
      busy      <= (state_n != IDLE);
    end
  end

  // Outputs are computed for the state being entered so they appear registered with it.
  always_comb begin
    state_n  = state;
    store_n  = store_q;
    data_n   = data_q;
    ready_n  = 1'b0;
    en_n     = 1'b0;
    rd_n     = 1'b0;
    addr_n   = dmem_addr;
    din_n    = dmem_din;
    memout_n = memout;
    rsp_n    = 1'b0;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (req_valid) begin
          ready_n = 1'b0;
          store_n = req_mode[0];
          data_n  = req_data;
          en_n    = 1'b1;
          addr_n  = req_addr;
          if (req_mode[1]) begin
            state_n = PTR_RD;
            rd_n    = 1'b1;
          end else begin
            state_n = DATA;
            rd_n    = ~req_mode[0];
            if (req_mode[0]) din_n = req_data;
          end
        end
      end
      PTR_RD: begin
        state_n = PTR_CAP;
      end
      // The pointer word is used verbatim as the data address.
      PTR_CAP: begin
        state_n = DATA;
        en_n    = 1'b1;
        rd_n    = ~store_q;
        addr_n  = dmem_dout;
        if (store_q) din_n = data_q;
      end
      DATA: begin
        if (store_q) begin
          state_n = IDLE;
          rsp_n   = 1'b1;
          ready_n = 1'b1;
        end else begin
          state_n = RD_CAP;
        end
      end
      RD_CAP: begin
        state_n  = IDLE;
        memout_n = dmem_dout;
        rsp_n    = 1'b1;
        ready_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

`ifdef LC3_MEMACC_ERR_CHECK_EN
  logic [1:0]  prev_mode;
  logic [15:0] prev_addr;
  logic        err_q;

  // Flags a stalled requester that changes its request before it is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_mode <= 2'b00;
      prev_addr <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      prev_mode <= req_mode;
      prev_addr <= req_addr;
      if (req_valid && busy && ((req_mode != prev_mode) || (req_addr != prev_addr)))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
// Self-checking bench for lc3_memaccess_ctrl: directed cases plus random requests
// checked against a transaction-level model of the memory and request semantics.
module tb_lc3_memaccess_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        dmem_en;
  logic        dmem_rd;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;
  logic [15:0] memout;
  logic        rsp_valid;
  logic        busy;
  logic        err;

  logic [15:0] mem [0:65535];
  logic [15:0] last_load;
  int          assert_count = 0;
  int          fail_count = 0;

  lc3_memaccess_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .dmem_en   (dmem_en),
    .dmem_rd   (dmem_rd),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_dout (dmem_dout),
    .memout    (memout),
    .rsp_valid (rsp_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clock = ~clock;

  task check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    end
  endtask

  task check_reset_values(input string tag);
    check_output({tag, "_ready"},  {15'd0, req_ready}, 16'd1);
    check_output({tag, "_en"},     {15'd0, dmem_en},   16'd0);
    check_output({tag, "_rd"},     {15'd0, dmem_rd},   16'd0);
    check_output({tag, "_addr"},   dmem_addr,          16'h0000);
    check_output({tag, "_din"},    dmem_din,           16'h0000);
    check_output({tag, "_memout"}, memout,             16'h0000);
    check_output({tag, "_rsp"},    {15'd0, rsp_valid}, 16'd0);
    check_output({tag, "_busy"},   {15'd0, busy},      16'd0);
    check_output({tag, "_err"},    {15'd0, err},       16'd0);
  endtask

  // Issue one request (called just after a falling edge) and follow it to completion.
  task apply_stimulus(input logic [1:0] mode, input logic [15:0] addr, input logic [15:0] data,
                      input int max_wait, output int wait_cycles);
    logic        is_store, indirect;
    logic [15:0] eff, exp_val;
    int          exp_lat, got_lat, n_acc;
    logic        a_rd   [4];
    logic [15:0] a_addr [4];
    logic [15:0] a_din  [4];
    is_store = mode[0];
    indirect = mode[1];
    eff      = indirect ? mem[addr] : addr;
    exp_val  = mem[eff];
    exp_lat  = (indirect ? 2 : 0) + (is_store ? 2 : 3);
    req_valid = 1'b1;
    req_mode  = mode;
    req_addr  = addr;
    req_data  = data;
    wait_cycles = 0;
    while (!req_ready && wait_cycles < max_wait) begin
      @(negedge clock);
      wait_cycles++;
    end
    if (!req_ready) begin
      check_output("accept_timeout", 16'd0, 16'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_mode  = 2'($urandom);
    req_addr  = 16'($urandom);
    check_output("busy_after_accept", {15'd0, busy}, 16'd1);
    check_output("ready_after_accept", {15'd0, req_ready}, 16'd0);
    got_lat = 0;
    n_acc = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clock);
      if (dmem_en) begin
        if (n_acc < 4) begin
          a_rd[n_acc]   = dmem_rd;
          a_addr[n_acc] = dmem_addr;
          a_din[n_acc]  = dmem_din;
        end
        n_acc++;
      end else begin
        check_output("rd_outside_access", {15'd0, dmem_rd}, 16'd0);
      end
      if (rsp_valid) begin
        got_lat = n;
        break;
      end
    end
    check_output("rsp_latency", 16'(got_lat), 16'(exp_lat));
    check_output("access_count", 16'(n_acc), indirect ? 16'd2 : 16'd1);
    if (n_acc == (indirect ? 2 : 1)) begin
      if (indirect) begin
        check_output("ptr_rd", {15'd0, a_rd[0]}, 16'd1);
        check_output("ptr_addr", a_addr[0], addr);
      end
      check_output("data_rd", {15'd0, a_rd[n_acc-1]}, {15'd0, ~is_store});
      check_output("data_addr", a_addr[n_acc-1], eff);
      if (is_store) check_output("data_din", a_din[n_acc-1], data);
    end
    if (is_store) begin
      check_output("mem_written", mem[eff], data);
    end else begin
      last_load = exp_val;
    end
    check_output("memout", memout, last_load);
    check_output("ready_at_rsp", {15'd0, req_ready}, 16'd1);
    check_output("busy_at_rsp", {15'd0, busy}, 16'd0);
  endtask

  // Start a request, then pull reset low during its cyc-th cycle.
  task reset_mid(input logic [1:0] mode, input logic [15:0] addr, input int cyc, input string tag);
    int rsp_seen;
    req_valid = 1'b1;
    req_mode  = mode;
    req_addr  = addr;
    req_data  = 16'h1111;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (cyc - 1) @(negedge clock);
    #1 reset = 1'b0;
    #1 check_reset_values(tag);
    @(negedge clock);
    reset = 1'b1;
    rsp_seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (rsp_valid) rsp_seen++;
    end
    check_output({tag, "_no_rsp"}, 16'(rsp_seen), 16'd0);
    check_output({tag, "_memout_kept"}, memout, 16'h0000);
    last_load = 16'h0000;
  endtask

  int          w;
  logic [1:0]  r_mode;
  logic [15:0] r_addr, r_data;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_mode  = 2'b00;
    req_addr  = 16'h0000;
    req_data  = 16'h0000;
    last_load = 16'h0000;
    dmem_dout = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    // Synchronous single-port memory: command sampled late in the cycle, applied at the rising edge.
    fork
      forever begin : mem_model
        logic        op_en, op_rd;
        logic [15:0] op_addr, op_din;
        @(negedge clock);
        #4;
        op_en   = dmem_en;
        op_rd   = dmem_rd;
        op_addr = dmem_addr;
        op_din  = dmem_din;
        @(posedge clock);
        if (op_en) begin
          if (op_rd) dmem_dout = mem[op_addr];
          else       mem[op_addr] = op_din;
        end
      end
    join_none

    #2 reset = 1'b0;
    #1 check_reset_values("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    mem[16'h2000] = 16'h2100;
    mem[16'h2100] = 16'h7777;
    reset_mid(2'b10, 16'h2000, 2, "rst_ptrcap");
    mem[16'h2200] = 16'h4444;
    reset_mid(2'b00, 16'h2200, 1, "rst_data");

    mem[16'h3000] = 16'hBEEF;
    apply_stimulus(2'b00, 16'h3000, 16'h0000, 4, w);
    check_output("ld_memout_beef", memout, 16'hBEEF);
    @(negedge clock);

    mem[16'h4000] = 16'h5000;
    apply_stimulus(2'b11, 16'h4000, 16'h1234, 4, w);
    check_output("sti_mem5000", mem[16'h5000], 16'h1234);
    check_output("sti_memout_held", memout, 16'hBEEF);
    @(negedge clock);

    mem[16'hFFFF] = 16'h0000;
    mem[16'h0000] = 16'hA5A5;
    apply_stimulus(2'b10, 16'hFFFF, 16'h0000, 4, w);
    check_output("ldi_boundary_memout", memout, 16'hA5A5);
    @(negedge clock);

    apply_stimulus(2'b01, 16'h3001, 16'h00FF, 4, w);
    apply_stimulus(2'b00, 16'h3001, 16'h0000, 4, w);
    check_output("b2b_accept_wait", 16'(w), 16'd0);
    check_output("b2b_memout", memout, 16'h00FF);

    for (int k = 0; k < 60; k++) begin
      r_mode = 2'($urandom_range(0, 3));
      r_addr = 16'($urandom);
      r_data = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r_addr = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) mem[r_addr] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
      apply_stimulus(r_mode, r_addr, r_data, 4, w);
      check_output("rnd_accept_wait", 16'(w), 16'd0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

`ifdef LC3_MEMACC_ERR_CHECK_EN
    @(negedge clock);
    check_output("err_clear_before", {15'd0, err}, 16'd0);
    req_valid = 1'b1;
    req_mode  = 2'b00;
    req_addr  = 16'h3000;
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    req_addr = 16'h3002;
    @(negedge clock);
    check_output("err_set", {15'd0, err}, 16'd1);
    req_valid = 1'b0;
    repeat (5) @(negedge clock);
    check_output("err_sticky", {15'd0, err}, 16'd1);
    #1 reset = 1'b0;
    #1 check_output("err_reset_clear", {15'd0, err}, 16'd0);
    @(negedge clock);
    reset = 1'b1;
`else
    @(negedge clock);
    check_output("err_tied_low", {15'd0, err}, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
